bot_port_master: RTL and testbench

Hardware port-bus initiator that drives the same KCPSM6-style port protocol that `picoblaze_if` responds to. It runs a fixed poll/command sequence with no processor involved:
- acknowledges the bot-update interrupt;
- reads LocX, LocY, BotInfo and Sensors;
- writes a motor-control byte and a sensor mirror to LEDs.

It sits in place of, or alongside via a port-bus mux, the KCPSM6 instance in the Nexys4 top level. It is used as an autopilot and as a bus exerciser for the interface block.

---
 rtl/bot_port_master.sv | 177 +++++++++++++++++
 tb/tb_bot_port_master.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bot_port_master.sv
// bot_port_master: hardware initiator on the KCPSM6-style port bus.
// It runs a fixed sequence with no processor involved:
//   1. optionally acknowledge the bot-update interrupt;
//   2. read LocX, LocY, BotInfo and Sensors into snapshot registers;
//   3. write the motor-control byte, then mirror the sensors to the LEDs.
// Every output is a flop that is loaded together with the next state, so the
// value an output shows always belongs to the state being entered.
module bot_port_master #(
  parameter logic [7:0] P_LOCX    = 8'h0A,
  parameter logic [7:0] P_LOCY    = 8'h0B,
  parameter logic [7:0] P_BOTINFO = 8'h0C,
  parameter logic [7:0] P_SENSORS = 8'h0D,
  parameter logic [7:0] P_MOTCTL  = 8'h09,
  parameter logic [7:0] P_LEDS    = 8'h02
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       start,
  input  logic [7:0] motctl_in,
  input  logic       interrupt,
  output logic       interrupt_ack,
  output logic [7:0] port_id,
  output logic [7:0] out_port,
  input  logic [7:0] in_port,
  output logic       read_strobe,
  output logic       write_strobe,
  output logic       k_write_strobe,
  output logic [7:0] locx,
  output logic [7:0] locy,
  output logic [7:0] botinfo,
  output logic [7:0] sensors,
  output logic       busy,
  output logic       done,
  output logic [7:0] seq_count
);

  typedef enum logic [2:0] {
    IDLE,
    ACK,
    RD_SETUP,
    RD_STROBE,
    WR_SETUP,
    WR_STROBE,
    DONE
  } state_t;

  state_t     state;
  logic [1:0] idx;

  // Read port address for a given read index.
  function automatic logic [7:0] rd_addr(input logic [1:0] i);
    logic [7:0] a;
    case (i)
      2'd0:    a = P_LOCX;
      2'd1:    a = P_LOCY;
      2'd2:    a = P_BOTINFO;
      default: a = P_SENSORS;
    endcase
    return a;
  endfunction

  // The constant-port write strobe is never used by this initiator.
  assign k_write_strobe = 1'b0;

  // Sequence controller: state, index, bus outputs and snapshots together.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      idx           <= '0;
      interrupt_ack <= 1'b0;
      port_id       <= '0;
      out_port      <= '0;
      read_strobe   <= 1'b0;
      write_strobe  <= 1'b0;
      locx          <= '0;
      locy          <= '0;
      botinfo       <= '0;
      sensors       <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      seq_count     <= '0;
    end else begin
      // Single-cycle outputs default low; only the transition into their
      // state raises them.
      interrupt_ack <= 1'b0;
      read_strobe   <= 1'b0;
      write_strobe  <= 1'b0;
      done          <= 1'b0;

      case (state)
        IDLE: begin
          port_id  <= '0;
          out_port <= '0;
          busy     <= 1'b0;
          // Interrupt wins over a simultaneous manual start.
          if (interrupt && enable) begin
            state         <= ACK;
            interrupt_ack <= 1'b1;
            busy          <= 1'b1;
          end else if (start) begin
            state   <= RD_SETUP;
            idx     <= '0;
            port_id <= rd_addr(2'd0);
            busy    <= 1'b1;
          end
        end

        ACK: begin
          state   <= RD_SETUP;
          idx     <= '0;
          port_id <= rd_addr(2'd0);
        end

        RD_SETUP: begin
          state       <= RD_STROBE;
          read_strobe <= 1'b1;
        end

        RD_STROBE: begin
          case (idx)
            2'd0:    locx    <= in_port;
            2'd1:    locy    <= in_port;
            2'd2:    botinfo <= in_port;
            default: sensors <= in_port;
          endcase
          if (idx != 2'd3) begin
            state   <= RD_SETUP;
            idx     <= idx + 2'd1;
            port_id <= rd_addr(idx + 2'd1);
          end else begin
            state    <= WR_SETUP;
            idx      <= '0;
            port_id  <= P_MOTCTL;
            out_port <= motctl_in;
          end
        end

        WR_SETUP: begin
          state        <= WR_STROBE;
          write_strobe <= 1'b1;
        end

        WR_STROBE: begin
          if (idx == 2'd0) begin
            // sensors already holds the value captured on the last read.
            state    <= WR_SETUP;
            idx      <= 2'd1;
            port_id  <= P_LEDS;
            out_port <= sensors;
          end else begin
            state     <= DONE;
            idx       <= '0;
            port_id   <= '0;
            out_port  <= '0;
            done      <= 1'b1;
            seq_count <= seq_count + 8'd1;
          end
        end

        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end

        default: begin
          state    <= IDLE;
          idx      <= '0;
          port_id  <= '0;
          out_port <= '0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bot_port_master.sv
// tb_bot_port_master: directed and randomized checks of bot_port_master
// against a timeline model of one sequence (position 1..14 from the trigger).
module tb_bot_port_master;

  logic       clk;
  logic       reset;
  logic       enable;
  logic       start;
  logic [7:0] motctl_in;
  logic       interrupt;
  logic       interrupt_ack;
  logic [7:0] port_id;
  logic [7:0] out_port;
  logic [7:0] in_port;
  logic       read_strobe;
  logic       write_strobe;
  logic       k_write_strobe;
  logic [7:0] locx, locy, botinfo, sensors;
  logic       busy;
  logic       done;
  logic [7:0] seq_count;

  int errors = 0;
  int checks = 0;

  // Port-space contents the interface would return.
  logic [7:0] mem [256];
  assign in_port = mem[port_id];

  bot_port_master #(
    .P_LOCX   (8'h0A),
    .P_LOCY   (8'h0B),
    .P_BOTINFO(8'h0C),
    .P_SENSORS(8'h0D),
    .P_MOTCTL (8'h09),
    .P_LEDS   (8'h02)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .enable        (enable),
    .start         (start),
    .motctl_in     (motctl_in),
    .interrupt     (interrupt),
    .interrupt_ack (interrupt_ack),
    .port_id       (port_id),
    .out_port      (out_port),
    .in_port       (in_port),
    .read_strobe   (read_strobe),
    .write_strobe  (write_strobe),
    .k_write_strobe(k_write_strobe),
    .locx          (locx),
    .locy          (locy),
    .botinfo       (botinfo),
    .sensors       (sensors),
    .busy          (busy),
    .done          (done),
    .seq_count     (seq_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] rd_port(input int i);
    logic [7:0] a;
    case (i)
      0:       a = 8'h0A;
      1:       a = 8'h0B;
      2:       a = 8'h0C;
      default: a = 8'h0D;
    endcase
    return a;
  endfunction

  // Reference model: position in the sequence timeline (0 = idle).
  int         m_pos = 0;
  logic [7:0] m_snap [4] = '{8'h00, 8'h00, 8'h00, 8'h00};
  logic [7:0] m_mot = 8'h00;
  logic [7:0] m_cnt = 8'h00;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_pos = 0;
      for (int i = 0; i < 4; i++) m_snap[i] = 8'h00;
      m_mot = 8'h00;
      m_cnt = 8'h00;
    end else begin
      if (m_pos == 3 || m_pos == 5 || m_pos == 7 || m_pos == 9)
        m_snap[(m_pos - 3) / 2] = mem[rd_port((m_pos - 3) / 2)];
      if (m_pos == 9) m_mot = motctl_in;
      if (m_pos == 0) begin
        if (interrupt && enable) m_pos = 1;
        else if (start)          m_pos = 2;
      end else if (m_pos == 14) begin
        m_pos = 0;
      end else begin
        m_pos = m_pos + 1;
      end
      if (m_pos == 14) m_cnt = m_cnt + 8'd1;
    end
  end

  // Per-cycle comparison of every output against the model.
  bit cmp_en = 1'b0;
  always @(negedge clk) begin
    logic       e_ack, e_rs, e_ws, e_busy, e_done;
    logic [7:0] e_pid, e_out;
    if (cmp_en) begin
      e_ack  = (m_pos == 1);
      e_rs   = (m_pos == 3 || m_pos == 5 || m_pos == 7 || m_pos == 9);
      e_ws   = (m_pos == 11 || m_pos == 13);
      e_busy = (m_pos >= 1 && m_pos <= 14);
      e_done = (m_pos == 14);
      e_pid  = 8'h00;
      e_out  = 8'h00;
      if (m_pos >= 2 && m_pos <= 9) e_pid = rd_port((m_pos - 2) / 2);
      if (m_pos == 10 || m_pos == 11) begin e_pid = 8'h09; e_out = m_mot; end
      if (m_pos == 12 || m_pos == 13) begin e_pid = 8'h02; e_out = m_snap[3]; end
      checks++;
      if (interrupt_ack !== e_ack || read_strobe !== e_rs || write_strobe !== e_ws ||
          busy !== e_busy || done !== e_done || port_id !== e_pid || out_port !== e_out ||
          k_write_strobe !== 1'b0 || locx !== m_snap[0] || locy !== m_snap[1] ||
          botinfo !== m_snap[2] || sensors !== m_snap[3] || seq_count !== m_cnt) begin
        errors++;
        $display("FAIL cycle_cmp t=%0t pos=%0d got ack%b rs%b ws%b bsy%b dn%b pid%h out%h snap%h%h%h%h cnt%h need ack%b rs%b ws%b bsy%b dn%b pid%h out%h snap%h%h%h%h cnt%h",
                 $time, m_pos, interrupt_ack, read_strobe, write_strobe, busy, done, port_id,
                 out_port, locx, locy, botinfo, sensors, seq_count, e_ack, e_rs, e_ws,
                 e_busy, e_done, e_pid, e_out, m_snap[0], m_snap[1], m_snap[2], m_snap[3], m_cnt);
      end
    end
  end

  // Bus activity log for literal checks.
  int          strobe_cnt = 0;
  logic [15:0] wq[$];
  always @(negedge clk) begin
    if (read_strobe || write_strobe) strobe_cnt++;
    if (write_strobe) wq.push_back({port_id, out_port});
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Trigger in cycle 0, then report the cycles holding ack and done.
  task automatic run_seq(input bit use_int, input bit use_start, input int mid_start,
                         output int ack_cyc, output int done_cyc);
    ack_cyc  = -1;
    done_cyc = -1;
    if (use_int)   interrupt = 1'b1;
    if (use_start) start = 1'b1;
    for (int n = 1; n <= 40 && done_cyc < 0; n++) begin
      tick();
      start = (n == mid_start);
      if (interrupt_ack) begin
        ack_cyc   = n;
        interrupt = 1'b0;
      end
      if (done) done_cyc = n;
    end
    start = 1'b0;
  endtask

  int ack_c, done_c, s0;

  initial begin
    reset = 1'b1; enable = 1'b0; start = 1'b0; interrupt = 1'b0; motctl_in = 8'h00;
    for (int i = 0; i < 256; i++) mem[i] = 8'(i);
    #1 reset = 1'b0;
    #1;
    check("reset_busy", busy, 0);
    check("reset_port_id", port_id, 0);
    check("reset_seq_count", seq_count, 0);
    check("reset_locx", locx, 0);
    cmp_en = 1'b1;
    tick(); tick();
    reset = 1'b1;

    // Idle: no strobes without a trigger.
    s0 = strobe_cnt;
    for (int i = 0; i < 20; i++) tick();
    check("idle_strobes", strobe_cnt - s0, 0);

    // Interrupt path with fixed read data.
    mem[8'h0A] = 8'h11; mem[8'h0B] = 8'h22; mem[8'h0C] = 8'h33; mem[8'h0D] = 8'h44;
    motctl_in = 8'h5A; enable = 1'b1;
    wq.delete();
    run_seq(1'b1, 1'b0, -1, ack_c, done_c);
    check("int_ack_cycle", ack_c, 1);
    check("int_done_cycle", done_c, 14);
    check("int_locx", locx, 8'h11);
    check("int_locy", locy, 8'h22);
    check("int_botinfo", botinfo, 8'h33);
    check("int_sensors", sensors, 8'h44);
    check("int_seq_count", seq_count, 1);
    check("int_write_count", wq.size(), 2);
    if (wq.size() == 2) begin
      check("int_write0", wq[0], 16'h095A);
      check("int_write1", wq[1], 16'h0244);
    end
    tick();

    // Manual start with interrupt pending but disabled.
    enable = 1'b0; interrupt = 1'b1;
    run_seq(1'b0, 1'b1, -1, ack_c, done_c);
    check("start_no_ack", ack_c, -1);
    check("start_done_cycle", done_c, 13);
    check("start_seq_count", seq_count, 2);
    tick(); tick();
    check("disabled_int_idle", busy, 0);
    interrupt = 1'b0;
    tick();

    // Simultaneous start and interrupt, plus a mid-sequence start.
    enable = 1'b1;
    run_seq(1'b1, 1'b1, 5, ack_c, done_c);
    check("both_ack_cycle", ack_c, 1);
    check("both_done_cycle", done_c, 14);
    tick(); tick(); tick();
    check("both_seq_count", seq_count, 3);
    check("both_idle_after", busy, 0);

    // Reset in cycle 6, during a read.
    interrupt = 1'b1;
    for (int n = 1; n <= 6; n++) begin
      tick();
      if (interrupt_ack) interrupt = 1'b0;
    end
    reset = 1'b0;
    #1;
    check("rst_mid_read_strobe", read_strobe, 0);
    check("rst_mid_busy", busy, 0);
    check("rst_mid_port_id", port_id, 0);
    check("rst_mid_locx", locx, 0);
    tick(); tick();
    reset = 1'b1;
    tick();
    run_seq(1'b1, 1'b0, -1, ack_c, done_c);
    check("post_rst_done_cycle", done_c, 14);
    check("post_rst_seq_count", seq_count, 1);
    check("post_rst_sensors", sensors, 8'h44);
    tick();

    // Randomized traffic, including occasional resets.
    for (int n = 0; n < 4000; n++) begin
      tick();
      if (interrupt_ack) interrupt = 1'b0;
      else if (!interrupt && $urandom_range(0, 19) == 0) interrupt = 1'b1;
      start     = ($urandom_range(0, 15) == 0);
      enable    = ($urandom_range(0, 3) != 0);
      motctl_in = 8'($urandom);
      reset     = ($urandom_range(0, 299) != 0);
      if ($urandom_range(0, 3) == 0) mem[rd_port(int'($urandom_range(0, 3)))] = 8'($urandom);
    end
    reset = 1'b1; start = 1'b0; interrupt = 1'b0;

    // 256 back-to-back start sequences from a fresh reset.
    tick();
    reset = 1'b0;
    tick();
    reset = 1'b1; enable = 1'b0;
    tick();
    begin
      int ndone, last, min_gap;
      ndone = 0; last = -1; min_gap = 1000;
      start = 1'b1;
      for (int n = 0; n < 256 * 14 + 60 && ndone < 256; n++) begin
        tick();
        if (done) begin
          if (last >= 0 && n - last < min_gap) min_gap = n - last;
          last = n;
          ndone++;
          if (ndone == 256) start = 1'b0;
        end
      end
      start = 1'b0;
      check("b2b_done_count", ndone, 256);
      check("b2b_min_gap", min_gap, 14);
      tick(); tick();
      check("b2b_seq_wrap", seq_count, 0);
      check("b2b_idle_after", busy, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
